// File: rtl/mem_pkg.sv
// Shared types and address decode for the wait-state data memory.
// MEM_BOUNDS_CHECK_EN (optional): when defined, out-of-range and
// misaligned accesses are rejected with resp_err.
package mem_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    ACCESS = 2'd2
  } state_t;

  typedef struct packed {
    logic        err;
    logic [31:0] idx;
  } decode_t;

  // Byte address -> word index (wrapped to DEPTH) plus a bounds/alignment flag.
  // Loops stand in for $clog2 so the helper works on plain int arguments.
  function automatic decode_t mem_decode(input logic [31:0] addr,
                                         input logic [31:0] base,
                                         input int          data_w,
                                         input int          depth);
    decode_t     d;
    logic [31:0] offset;
    logic [31:0] word;
    int          lanes;
    int          sh;
    lanes  = data_w / BYTE_W;
    sh     = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < lanes) sh = i + 1;
    offset = addr - base;
    word   = offset >> sh;
    d.idx  = word & (32'(depth) - 32'd1);
    d.err  = (addr < base) || (word >= 32'(depth)) ||
             ((offset & (32'(lanes) - 32'd1)) != 32'd0);
    return d;
  endfunction

endpackage

// File: rtl/mem_array.sv
// Single-port synchronous RAM, DEPTH x DATA_W, byte-lane write enables.
// Read data is registered and only changes on a read, so it holds between reads.
module mem_array
  import mem_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 65536,
  localparam int AW    = $clog2(DEPTH),
  localparam int LANES = DATA_W / BYTE_W
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [LANES-1:0]  be,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Byte-masked write or full-word read on the enabled edge.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int i = 0; i < LANES; i++)
          if (be[i]) mem[addr][i*BYTE_W +: BYTE_W] <= wdata[i*BYTE_W +: BYTE_W];
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/data_memory_ws.sv
// MEM-stage data memory with valid/ready request and programmable wait states.
// Accept -> WAIT_CYCLES idle cycles -> one ACCESS cycle -> one-cycle response.
// MEM_BOUNDS_CHECK_EN (optional): reject out-of-range/misaligned addresses.
module data_memory_ws
  import mem_pkg::*;
#(
  parameter int          DATA_W      = 32,
  parameter int          DEPTH       = 65536,
  parameter int unsigned BASE_ADDR   = 1024,
  parameter int          WAIT_CYCLES = 2,
  localparam int         LANES       = DATA_W / BYTE_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_write,
  input  logic [31:0]       req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [LANES-1:0]  req_be,
  output logic              req_ready,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

  state_t            state, state_nx;
  logic [CNT_W-1:0]  cnt, cnt_nx;

  logic              wr_q;
  logic [31:0]       addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [LANES-1:0]  be_q;

  decode_t           dec;
  logic              acc_err;
  logic              ram_en;
  logic [DATA_W-1:0] ram_q;
  logic              rd_zero;
  logic              dec_unused;

  assign dec = mem_decode(addr_q, 32'(BASE_ADDR), DATA_W, DEPTH);

`ifdef MEM_BOUNDS_CHECK_EN
  assign acc_err = dec.err;
`else
  assign acc_err = 1'b0;
`endif
  assign dec_unused = ^{dec.idx[31:AW], dec.err};

  // Ready comes straight from the state register: no path from req_valid.
  assign req_ready = (state == IDLE);
  assign ram_en    = (state == ACCESS) && !acc_err;

  // State and wait counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // Next-state: wait count is preloaded with WAIT_CYCLES-1 so ACCESS lands
  // exactly WAIT_CYCLES cycles after the accept edge.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      IDLE: begin
        if (req_valid) begin
          if (WAIT_CYCLES > 0) begin
            state_nx = WAIT;
            cnt_nx   = CNT_W'(WAIT_CYCLES - 1);
          end else begin
            state_nx = ACCESS;
          end
        end
      end
      WAIT: begin
        if (cnt == '0) state_nx = ACCESS;
        else           cnt_nx   = cnt - 1'b1;
      end
      ACCESS:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Capture the request on the accept edge; held through WAIT and ACCESS.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
    end else if (req_ready && req_valid) begin
      wr_q    <= req_write;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
      be_q    <= req_be;
    end
  end

  // Response registers: one-cycle pulse on the edge closing ACCESS.
  // rd_zero forces rdata to 0 after reset or an error, otherwise the RAM's
  // read register (which only moves on reads) supplies the held value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      rd_zero    <= 1'b1;
    end else begin
      resp_valid <= (state == ACCESS);
      if (state == ACCESS) begin
        resp_err <= acc_err;
        if (acc_err)   rd_zero <= 1'b1;
        else if (!wr_q) rd_zero <= 1'b0;
      end
    end
  end

  assign resp_rdata = rd_zero ? '0 : ram_q;

  mem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk   (clk),
    .en    (ram_en),
    .we    (wr_q),
    .be    (be_q),
    .addr  (dec.idx[AW-1:0]),
    .wdata (wdata_q),
    .rdata (ram_q)
  );

endmodule

// File: tb/tb_data_memory_ws.sv
// Directed bench for data_memory_ws: default instance (2 wait states) plus a
// small zero-wait instance. Expected values are hand-computed constants.
module tb_data_memory_ws;

  logic        clk;
  logic        rst;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        v1, v0;
  logic        r1, rv1, re1, r0, rv0, re0;
  logic [31:0] rd1, rd0;
  logic        sel;
  int          cyc;
  int          checks;
  int          errors;

  wire         rdy_s = sel ? r0  : r1;
  wire         rv_s  = sel ? rv0 : rv1;
  wire         re_s  = sel ? re0 : re1;
  wire [31:0]  rd_s  = sel ? rd0 : rd1;

  data_memory_ws u_dut (
    .clk(clk), .rst(rst), .req_valid(v1), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .req_ready(r1), .resp_valid(rv1), .resp_rdata(rd1), .resp_err(re1)
  );

  data_memory_ws #(.DEPTH(16), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .rst(rst), .req_valid(v0), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .req_ready(r0), .resp_valid(rv0), .resp_rdata(rd0), .resp_err(re0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one request on the selected instance as soon as it is ready and
  // wait (bounded) for its response pulse.
  task automatic req(input logic w, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] be, output logic [31:0] rd,
                     output logic er, output int acc);
    int n;
    int lat;
    n = 0;
    while (!rdy_s && n < 20) begin
      @(posedge clk); #1; n++;
    end
    chk("ready_before_req", {31'd0, rdy_s}, 32'd1);
    req_write = w; req_addr = a; req_wdata = d; req_be = be;
    if (sel) v0 = 1'b1; else v1 = 1'b1;
    @(posedge clk); #1;
    acc = cyc;
    v0 = 1'b0; v1 = 1'b0;
    chk("no_resp_at_accept", {31'd0, rv_s}, 32'd0);
    lat = -1; rd = 'x; er = 1'bx;
    for (int i = 1; i <= 12; i++) begin
      @(posedge clk); #1;
      if (rv_s) begin
        lat = i; rd = rd_s; er = re_s;
        break;
      end
    end
    chk("latency", 32'(lat), sel ? 32'd1 : 32'd3);
  endtask

  logic [31:0] rd;
  logic        er;
  int          a1, a2, a3, pulses;

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    checks = 0; errors = 0; cyc = 0; sel = 1'b0;
    rst = 1'b0; v1 = 1'b0; v0 = 1'b0;
    req_write = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0;

    // Reset values.
    #12;
    chk("rst_ready", {31'd0, r1}, 32'd1);
    chk("rst_resp_valid", {31'd0, rv1}, 32'd0);
    chk("rst_rdata", rd1, 32'd0);
    chk("rst_err", {31'd0, re1}, 32'd0);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_ready", {31'd0, r1}, 32'd1);
    chk("post_rst_resp_valid", {31'd0, rv1}, 32'd0);

    // Full-word write then read back.
    req(1'b1, 32'd1024, 32'hDEADBEEF, 4'hF, rd, er, a1);
    chk("wr1024_err", {31'd0, er}, 32'd0);
    req(1'b0, 32'd1024, 32'h0, 4'h0, rd, er, a1);
    chk("rd1024_data", rd, 32'hDEADBEEF);
    chk("rd1024_err", {31'd0, er}, 32'd0);

    // Byte-lane merge.
    req(1'b1, 32'd1028, 32'h11223344, 4'hF, rd, er, a1);
    req(1'b1, 32'd1028, 32'h0000AA00, 4'b0010, rd, er, a1);
    req(1'b0, 32'd1028, 32'h0, 4'h0, rd, er, a1);
    chk("rd1028_merge", rd, 32'h1122AA44);

    // be=0 write is a no-op but still responds.
    req(1'b1, 32'd1028, 32'hFFFFFFFF, 4'h0, rd, er, a1);
    req(1'b0, 32'd1028, 32'h0, 4'h0, rd, er, a1);
    chk("rd1028_be0_noop", rd, 32'h1122AA44);

    // Back-to-back reads.
    req(1'b1, 32'd1032, 32'h0, 4'hF, rd, er, a1);
    req(1'b0, 32'd1024, 32'h0, 4'h0, rd, er, a1);
    chk("b2b_rd0", rd, 32'hDEADBEEF);
    req(1'b0, 32'd1028, 32'h0, 4'h0, rd, er, a2);
    chk("b2b_rd1", rd, 32'h1122AA44);
    req(1'b0, 32'd1032, 32'h0, 4'h0, rd, er, a3);
    chk("b2b_rd2", rd, 32'h00000000);
    chk("b2b_gap1", 32'(a2 - a1), 32'd4);
    chk("b2b_gap2", 32'(a3 - a2), 32'd4);

    // Reset during WAIT of a write: discarded.
    req_write = 1'b1; req_addr = 32'd1032; req_wdata = 32'h55; req_be = 4'hF;
    v1 = 1'b1;
    @(posedge clk); #1;
    v1 = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("midrst_ready", {31'd0, r1}, 32'd1);
    chk("midrst_resp_valid", {31'd0, rv1}, 32'd0);
    #2 rst = 1'b1;
    pulses = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (rv1) pulses++;
    end
    chk("midrst_no_resp", 32'(pulses), 32'd0);
    req(1'b0, 32'd1032, 32'h0, 4'h0, rd, er, a1);
    chk("midrst_rd1032", rd, 32'h00000000);

    // Boundary addresses.
`ifdef MEM_BOUNDS_CHECK_EN
    req(1'b1, 32'd1020, 32'hA5A5A5A5, 4'hF, rd, er, a1);
    chk("bc_below_err", {31'd0, er}, 32'd1);
    chk("bc_below_rdata", rd, 32'd0);
    req(1'b1, 32'd1026, 32'hCAFEF00D, 4'hF, rd, er, a1);
    chk("bc_misalign_err", {31'd0, er}, 32'd1);
    chk("bc_misalign_rdata", rd, 32'd0);
    req(1'b1, 32'd263168, 32'h0BADC0DE, 4'hF, rd, er, a1);
    chk("bc_over_err", {31'd0, er}, 32'd1);
    chk("bc_over_rdata", rd, 32'd0);
    req(1'b0, 32'd1024, 32'h0, 4'h0, rd, er, a1);
    chk("bc_word0_unchanged", rd, 32'hDEADBEEF);
    chk("bc_word0_err", {31'd0, er}, 32'd0);
    req(1'b0, 32'd1020, 32'h0, 4'h0, rd, er, a1);
    chk("bc_rd_below_err", {31'd0, er}, 32'd1);
    chk("bc_rd_below_rdata", rd, 32'd0);
`else
    req(1'b1, 32'd1020, 32'hA5A5A5A5, 4'hF, rd, er, a1);
    chk("nb_below_err", {31'd0, er}, 32'd0);
    req(1'b1, 32'd1026, 32'hCAFEF00D, 4'hF, rd, er, a1);
    chk("nb_misalign_err", {31'd0, er}, 32'd0);
    req(1'b1, 32'd263168, 32'h0BADC0DE, 4'hF, rd, er, a1);
    chk("nb_over_err", {31'd0, er}, 32'd0);
    req(1'b0, 32'd1024, 32'h0, 4'h0, rd, er, a1);
    chk("nb_alias_word0", rd, 32'h0BADC0DE);
    req(1'b0, 32'd1020, 32'h0, 4'h0, rd, er, a1);
    chk("nb_wrap_top_word", rd, 32'hA5A5A5A5);
`endif

    // Zero-wait instance.
    sel = 1'b1;
    req(1'b1, 32'd1024, 32'h13579BDF, 4'hF, rd, er, a1);
    req(1'b0, 32'd1024, 32'h0, 4'h0, rd, er, a2);
    chk("w0_rd_data", rd, 32'h13579BDF);
    chk("w0_gap", 32'(a2 - a1), 32'd2);
    sel = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
